// File: rtl/fetch_unit.sv
// Instruction fetch front end: buffers one 32-bit memory word and issues its two
// 16-bit instructions in order (upper half first), with redirect and stall support.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] ir,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [15:0] issue_cnt
);

  // state | meaning
  // EMPTY | no buffered word; next edge loads the word at pc
  // HI    | offering wbuf[31:16] at wpc
  // LO    | offering wbuf[15:0] at wpc+2; a transfer reloads straight into HI
  typedef enum logic [1:0] {EMPTY, HI, LO} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] wpc_q, wpc_d;
  logic        start_lo_q, start_lo_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic        xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      pc_q        <= 32'd0;
      wbuf_q      <= 32'd0;
      wpc_q       <= 32'd0;
      start_lo_q  <= 1'b0;
      issue_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wbuf_q      <= wbuf_d;
      wpc_q       <= wpc_d;
      start_lo_q  <= start_lo_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Outputs depend only on registered state.
  always_comb begin
    instr       = 16'd0;
    instr_pc    = 32'd0;
    instr_valid = 1'b0;
    case (state_q)
      HI: begin
        instr       = wbuf_q[31:16];
        instr_pc    = wpc_q;
        instr_valid = 1'b1;
      end
      LO: begin
        instr       = wbuf_q[15:0];
        instr_pc    = wpc_q + 32'd2;
        instr_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer = instr_valid && dec_ready && !redirect;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wbuf_d      = wbuf_q;
    wpc_d       = wpc_q;
    start_lo_d  = start_lo_q;
    issue_cnt_d = issue_cnt_q + {15'd0, xfer};
    if (redirect) begin
      pc_d       = {redirect_target[31:2], 2'b00};
      start_lo_d = redirect_target[1];
      state_d    = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          wbuf_d     = ir;
          wpc_d      = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = start_lo_q ? LO : HI;
          start_lo_d = 1'b0;
        end
        HI: begin
          if (xfer) state_d = LO;
        end
        LO: begin
          if (xfer) begin
            wbuf_d  = ir;
            wpc_d   = pc_q;
            pc_d    = pc_q + 32'd4;
            state_d = HI;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign pc        = pc_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a combinational instruction-memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [15:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        dec_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [15:0] issue_cnt;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .ir(ir), .instr(instr),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .dec_ready(dec_ready),
    .redirect(redirect), .redirect_target(redirect_target), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // Word 0 is the reference word, address 8 holds an all-zero word (nops),
  // every other halfword is its own address XOR 0xC3C3.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [15:0] h0, h1;
    if (a == 32'd0) return 32'h200A88C9;
    if (a == 32'd8) return 32'd0;
    h0 = a[15:0] ^ 16'hC3C3;
    h1 = (a[15:0] + 16'd2) ^ 16'hC3C3;
    return {h0, h1};
  endfunction

  always_comb ir = word_at(pc);

  typedef struct {
    logic        rst, dr, rd;
    logic [31:0] tgt;
    logic        chk, v;
    logic [15:0] ins;
    logic [31:0] ipc, pcx;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [15:0] ins,
                            input logic [31:0] ipc, input logic [31:0] pcx, input logic [15:0] cnt);
    check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
    check({tag, ".instr"}, {16'd0, instr}, {16'd0, ins});
    check({tag, ".instr_pc"}, instr_pc, ipc);
    check({tag, ".pc"}, pc, pcx);
    check({tag, ".issue_cnt"}, {16'd0, issue_cnt}, {16'd0, cnt});
  endtask

  initial begin
    //         rst   dr    rd    tgt            chk   v     instr     instr_pc       pc             cnt
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 16'h0,    32'h0,         32'h0,         16'd0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 16'h0,    32'h0,         32'h0,         16'd0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'h200A, 32'h0,         32'h4,         16'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'h88C9, 32'h2,         32'h4,         16'd1};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 16'hC3C7, 32'h4,         32'h8,         16'd2};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 16'hC3C7, 32'h4,         32'h8,         16'd2};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 16'hC3C7, 32'h4,         32'h8,         16'd2};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'hC3C7, 32'h4,         32'h8,         16'd2};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'hC3C5, 32'h6,         32'h8,         16'd3};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'h0000, 32'h8,         32'hC,         16'd4};
    vt[10] = '{1'b0, 1'b1, 1'b1, 32'h10,        1'b1, 1'b1, 16'h0000, 32'hA,         32'hC,         16'd5};
    vt[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 16'h0,    32'h0,         32'h10,        16'd5};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'hC3D3, 32'h10,        32'h14,        16'd5};
    vt[13] = '{1'b0, 1'b1, 1'b1, 32'h1A,        1'b1, 1'b1, 16'hC3D1, 32'h12,        32'h14,        16'd6};
    vt[14] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 16'h0,    32'h0,         32'h18,        16'd6};
    vt[15] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'hC3D9, 32'h1A,        32'h1C,        16'd6};
    vt[16] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'hC3DF, 32'h1C,        32'h20,        16'd7};
    vt[17] = '{1'b0, 1'b1, 1'b1, 32'h1B,        1'b1, 1'b1, 16'hC3DD, 32'h1E,        32'h20,        16'd8};
    vt[18] = '{1'b0, 1'b1, 1'b1, 32'hFFFFFFFC,  1'b1, 1'b0, 16'h0,    32'h0,         32'h18,        16'd8};
    vt[19] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 16'h0,    32'h0,         32'hFFFFFFFC,  16'd8};
    vt[20] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'h3C3F, 32'hFFFFFFFC,  32'h0,         16'd8};
    vt[21] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'h3C3D, 32'hFFFFFFFE,  32'h0,         16'd9};
    vt[22] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'h200A, 32'h0,         32'h4,         16'd10};
    vt[23] = '{1'b1, 1'b1, 1'b1, 32'h40,        1'b1, 1'b1, 16'h88C9, 32'h2,         32'h4,         16'd11};
    vt[24] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 16'h0,    32'h0,         32'h0,         16'd0};
    vt[25] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 16'h200A, 32'h0,         32'h4,         16'd0};

    reset = 1'b1; dec_ready = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
    #1;
    for (int i = 0; i < 26; i++) begin
      reset = vt[i].rst; dec_ready = vt[i].dr;
      redirect = vt[i].rd; redirect_target = vt[i].tgt;
      #1;
      if (vt[i].chk) check_outs($sformatf("vec%0d", i), vt[i].v, vt[i].ins, vt[i].ipc, vt[i].pcx, vt[i].cnt);
      @(posedge clk); #1;
    end

    // Now in LO at 0x2: outputs must not react to same-cycle input changes.
    reset = 1'b0; dec_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h80;
    #1;
    check_outs("no_comb_path", 1'b1, 16'h88C9, 32'h2, 32'h4, 16'd1);
    dec_ready = 1'b1; redirect = 1'b0;
    #1;
    check_outs("no_comb_path2", 1'b1, 16'h88C9, 32'h2, 32'h4, 16'd1);

    // issue_cnt wraps after 65536 transfers.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; dec_ready = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    check("cnt_max", {16'd0, issue_cnt}, 32'h0000FFFF);
    @(posedge clk); #1;
    check("cnt_wrap", {16'd0, issue_cnt}, 32'h00000000);
    check("wrap_valid", {31'd0, instr_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
